// File: rtl/util_delay_chk.sv
// util_delay_chk
// Monitor for the far end of a fixed-latency delay path. The stimulus fed into
// the path (in) goes through a private DELAY-deep history that starts filled
// with RESET. The path output (out) is compared against that history every
// cycle. Per-cycle match, a sticky fail flag, saturating error/check counters
// and the cycle index of the first mismatch are reported.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous restart, same effect as rst at the next edge
//   in         stimulus driven into the observed path this cycle (WIDTH)
//   out        observed path output this cycle (WIDTH)
//   valid      current cycle is being compared
//   match      out equals expected this cycle (1 whenever valid = 0)
//   fail       sticky, set by any counted mismatch
//   errors     saturating count of counted mismatches (CNT_W)
//   checked    saturating count of compared cycles (CNT_W)
//   first_err  cycle index of the first counted mismatch, all-ones if none
module util_delay_chk #(
    parameter int   DELAY        = 0,
    parameter logic RESET        = 1'b0,
    parameter int   WIDTH        = 1,
    parameter int   CNT_W        = 16,
    parameter bit   CHECK_WARMUP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             match,
    output logic             fail,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] checked,
    output logic [CNT_W-1:0] first_err
);

    localparam logic [0:0]       ST_WARMUP = 1'b0;
    localparam logic [0:0]       ST_CHECK  = 1'b1;
    // A combinational path has no warm-up at all.
    localparam logic [0:0]       ST_INIT   = (DELAY == 0) ? ST_CHECK : ST_WARMUP;
    localparam logic [WIDTH-1:0] RESET_VEC = {WIDTH{RESET}};
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [WIDTH-1:0] expected;
    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cycle_reg;
    logic             fail_reg;
    logic [CNT_W-1:0] errors_reg;
    logic [CNT_W-1:0] checked_reg;
    logic [CNT_W-1:0] first_err_reg;
    logic [31:0]      cycle_ext;
    logic             mismatch;

    generate
        if (DELAY == 0) begin : g_comb
            assign expected = in;
        end else begin : g_hist
            logic [WIDTH-1:0] hist_reg [DELAY];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) hist_reg[i] <= RESET_VEC;
                end else if (clear) begin
                    for (int i = 0; i < DELAY; i++) hist_reg[i] <= RESET_VEC;
                end else begin
                    hist_reg[0] <= in;
                    for (int i = 1; i < DELAY; i++) hist_reg[i] <= hist_reg[i-1];
                end
            end

            assign expected = hist_reg[DELAY-1];
        end
    endgenerate

    assign cycle_ext = 32'(cycle_reg);

    // Case inequality so that X/Z on out is counted as a mismatch.
    assign mismatch = (out !== expected);
    assign valid    = (state_reg == ST_CHECK) | CHECK_WARMUP;
    assign match    = !valid | !mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            cycle_reg     <= '0;
            fail_reg      <= 1'b0;
            errors_reg    <= '0;
            checked_reg   <= '0;
            first_err_reg <= CNT_MAX;
        end else if (clear) begin
            // A mismatch presented together with clear is discarded.
            state_reg     <= ST_INIT;
            cycle_reg     <= '0;
            fail_reg      <= 1'b0;
            errors_reg    <= '0;
            checked_reg   <= '0;
            first_err_reg <= CNT_MAX;
        end else begin
            if (cycle_reg != CNT_MAX) begin
                cycle_reg <= cycle_reg + 1'b1;
            end
            // Leave warm-up on the edge that brings the cycle count to DELAY.
            if (state_reg == ST_WARMUP && (cycle_ext + 32'd1 >= 32'(DELAY))) begin
                state_reg <= ST_CHECK;
            end
            if (valid) begin
                if (checked_reg != CNT_MAX) begin
                    checked_reg <= checked_reg + 1'b1;
                end
                if (mismatch) begin
                    fail_reg <= 1'b1;
                    if (errors_reg != CNT_MAX) begin
                        errors_reg <= errors_reg + 1'b1;
                    end
                    // Only the first counted mismatch is recorded.
                    if (first_err_reg == CNT_MAX) begin
                        first_err_reg <= cycle_reg;
                    end
                end
            end
        end
    end

    assign fail      = fail_reg;
    assign errors    = errors_reg;
    assign checked   = checked_reg;
    assign first_err = first_err_reg;

endmodule
